// File: rtl/operand_fetch_if.sv
// Handshake and register-file bus bundle for the operand fetch stage.
// slave is the stage's view of the bus; master is the surrounding pipeline's view.
interface operand_fetch_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic [3:0]  raddr0_;
  logic [3:0]  raddr1_;
  logic [15:0] rdata0;
  logic [15:0] rdata1;
  logic        wb_wen;
  logic [3:0]  wb_waddr;
  logic [15:0] wb_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_va;
  logic [15:0] out_vb;

  modport slave (
    input  in_valid, in_instr, in_pc, rdata0, rdata1,
           wb_wen, wb_waddr, wb_wdata, out_ready,
    output in_ready, raddr0_, raddr1_, out_valid, out_instr, out_pc, out_va, out_vb
  );

  modport master (
    output in_valid, in_instr, in_pc, rdata0, rdata1,
           wb_wen, wb_waddr, wb_wdata, out_ready,
    input  in_ready, raddr0_, raddr1_, out_valid, out_instr, out_pc, out_va, out_vb
  );
endinterface

// File: rtl/operand_fetch.sv
// Register-read stage: S1 holds the instruction whose register reads are in
// flight, S2 is the output register towards execute. Same-cycle writebacks are
// bypassed into S1's operands, and a held S2 snoops writebacks so its operands
// never go stale while execute stalls.
module operand_fetch #(
  parameter int RA_LSB  = 8,
  parameter int RB_LSB  = 4,
  parameter bit ZERO_R0 = 1'b1
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  operand_fetch_if.slave bus
);

  logic        s1_valid;
  logic [15:0] s1_instr;
  logic [15:0] s1_pc;

  logic        out_valid_q;
  logic [15:0] out_instr_q;
  logic [15:0] out_pc_q;
  logic [15:0] out_va_q;
  logic [15:0] out_vb_q;

  logic        s2_free;
  logic        s1_adv;
  logic        in_ready_c;
  logic        accept;
  logic [3:0]  in_ra, in_rb, s1_ra, s1_rb, s2_ra, s2_rb;
  logic [15:0] op_a, op_b;
  logic        snoop_a, snoop_b;

  // True when a writeback lands on a register that is really stored (r0 may be hardwired).
  function automatic logic wb_hits(input logic [3:0] src, input logic wen, input logic [3:0] waddr);
    return wen && (waddr == src) && !(ZERO_R0 && (src == 4'd0));
  endfunction

  // Operand value for a source: hardwired zero, then bypassed writeback, then register file.
  function automatic logic [15:0] pick_operand(input logic [3:0] src, input logic [15:0] rdata,
                                               input logic wen, input logic [3:0] waddr,
                                               input logic [15:0] wdata);
    if (ZERO_R0 && (src == 4'd0))
      return 16'h0000;
    else if (wen && (waddr == src))
      return wdata;
    else
      return rdata;
  endfunction

  // Handshake, read-address steering and operand selection.
  always_comb begin
    in_ra      = bus.in_instr[RA_LSB +: 4];
    in_rb      = bus.in_instr[RB_LSB +: 4];
    s1_ra      = s1_instr[RA_LSB +: 4];
    s1_rb      = s1_instr[RB_LSB +: 4];
    s2_ra      = out_instr_q[RA_LSB +: 4];
    s2_rb      = out_instr_q[RB_LSB +: 4];
    s2_free    = !out_valid_q || bus.out_ready;
    s1_adv     = s1_valid && s2_free;
    in_ready_c = (!s1_valid || s2_free) && !flush && !rst;
    accept     = bus.in_valid && in_ready_c;
    op_a       = pick_operand(s1_ra, bus.rdata0, bus.wb_wen, bus.wb_waddr, bus.wb_wdata);
    op_b       = pick_operand(s1_rb, bus.rdata1, bus.wb_wen, bus.wb_waddr, bus.wb_wdata);
    snoop_a    = wb_hits(s2_ra, bus.wb_wen, bus.wb_waddr);
    snoop_b    = wb_hits(s2_rb, bus.wb_wen, bus.wb_waddr);
  end

  // While S1 is stalled it keeps re-reading its own sources so rdata stays aligned with it.
  assign bus.raddr0_ = in_ready_c ? in_ra : s1_ra;
  assign bus.raddr1_ = in_ready_c ? in_rb : s1_rb;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_va    = out_va_q;
  assign bus.out_vb    = out_vb_q;

  // Slot state: reset clears everything, flush only kills valids, otherwise advance/hold/snoop.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_instr    <= '0;
      s1_pc       <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_va_q    <= '0;
      out_vb_q    <= '0;
    end else if (flush) begin
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_instr <= bus.in_instr;
        s1_pc    <= bus.in_pc;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        out_valid_q <= 1'b1;
        out_instr_q <= s1_instr;
        out_pc_q    <= s1_pc;
        out_va_q    <= op_a;
        out_vb_q    <= op_b;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end else if (out_valid_q) begin
        if (snoop_a) out_va_q <= bus.wb_wdata;
        if (snoop_b) out_vb_q <= bus.wb_wdata;
      end
    end
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Register-read pipeline stage sitting directly downstream of the 16x16 register file.
- Accepts decoded instructions over a valid/ready handshake and drives the register file's two read addresses.
- Captures the two 16-bit operands one cycle later, bypassing any same-cycle writeback, and hands instruction, PC and operands to execute through a registered output with valid/ready.
- Two internal slots: S1 (read in flight) and S2 (output register). Full throughput is one instruction per cycle.

Parameters:
- RA_LSB, 8, LSB of 4-bit source-A register field in instr
- RB_LSB, 4, LSB of 4-bit source-B register field in instr
- ZERO_R0, 1, when 1, any operand sourced from register 0 reads as 16'h0000 regardless of register file or bypass

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous pipeline kill (branch redirect)
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage accepts in_instr/in_pc this cycle
- in_instr  in  16  instruction word
- in_pc  in  16  instruction address
- raddr0_  out  4  register file read address A (register file registers it)
- raddr1_  out  4  register file read address B
- rdata0  in  16  register file read data A (addresses from previous cycle)
- rdata1  in  16  register file read data B
- wb_wen  in  1  writeback enable (same signal driving the register file write port)
- wb_waddr  in  4  writeback address
- wb_wdata  in  16  writeback data
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts this cycle
- out_instr  out  16  instruction
- out_pc  out  16  PC
- out_va  out  16  operand A
- out_vb  out  16  operand B

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Fields: ra = instr[RA_LSB+3:RA_LSB], rb = instr[RB_LSB+3:RB_LSB].
- State: s1_valid, s1_instr, s1_pc; S2 holds out_valid, out_instr, out_pc, out_va, out_vb.
- s2_free = !out_valid | out_ready. s1_adv = s1_valid & s2_free.
- in_ready = (!s1_valid | s2_free) & !flush & !rst. It is combinational and depends on out_ready.
- raddr0_/raddr1_ = in_ready ? ra/rb of in_instr : ra/rb of s1_instr. This guarantees rdata0/rdata1 always correspond to S1's sources during any cycle S1 is valid.
- Operand select (S1 sources), priority order:
  - ZERO_R0 & src==0 -> 0
  - wb_wen & wb_waddr==src -> wb_wdata
  - otherwise rdata.
- Edge updates:
  - accept (in_valid & in_ready): S1 <= in_instr/in_pc, s1_valid <= 1.
  - S1 otherwise: if s1_adv, s1_valid <= 0.
  - s1_adv: S2 <= S1 instr/pc plus selected operands, out_valid <= 1.
  - S2 otherwise: if out_ready, out_valid <= 0.
- S2 hold snoop: while out_valid & !out_ready, a wb write with wb_waddr == out_instr's ra (or rb) updates out_va (or out_vb) with wb_wdata at that edge. Register 0 is excluded when ZERO_R0=1. A write to a register that is both ra and rb updates both.
- Latency: accepted at edge k -> out_valid high in cycle k+1 (earliest). No bubbles under continuous in_valid/out_ready.
- Back-pressure: S1 and S2 both full and out_ready=0 -> in_ready=0; S1 keeps re-reading its own sources each cycle.
- flush:
  - at the next edge, s1_valid <= 0 and out_valid <= 0;
  - nothing accepted in a flush cycle;
  - flush overrides a simultaneous accept or advance;
  - data registers are left unchanged.
- rst:
  - at the next edge, s1_valid=0, out_valid=0, out_instr=0, out_pc=0, out_va=0, out_vb=0, s1_instr=0, s1_pc=0;
  - in_ready=0 while rst is high;
  - in-flight instructions are dropped (reset mid-operation has no partial output).
- Stability: out_* are stable while out_valid & !out_ready, except for the snoop updates to out_va/out_vb.

Test Plan:
- Register file preloaded r3=0x1234, r5=0xBEEF. instr=0x0350 (ra=3, rb=5) accepted at edge 1, out_ready=1 -> cycle 2: out_valid=1, out_va=0x1234, out_vb=0xBEEF, out_pc echoed.
- Bypass: in the cycle S1 holds ra=3, wb_wen=1, wb_waddr=3, wb_wdata=0x0042 -> out_va=0x0042, not 0x1234.
- Hold snoop: out_ready=0 with S2 holding ra=5. Write r5=0x7777 -> out_va becomes 0x7777 next edge. Raise out_ready -> that value is consumed. Meanwhile a new instruction stays in S1, in_ready=0, and raddr0_/raddr1_ equal S1's fields.
- r0: ra=0 with register file r0 written to 0xFFFF and wb writing r0=0xAAAA simultaneously -> out_va=0x0000 (ZERO_R0=1).
- Streaming: 8 back-to-back instructions, in_valid=out_ready=1 -> 8 consecutive out_valid cycles in order, no bubbles, correct operands each.
- flush with both slots full and in_valid=1 -> next cycle out_valid=0, s1 empty, input not accepted. Repeat with rst mid-stream -> all outputs 0.
